// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// It inhibits the bus, issues a request-to-send, shifts out one byte plus odd
// parity and a stop bit on device-generated clocks, then samples the ACK bit.
// The open-collector pads are driven through active-high pull-low enables.
// Optional feature macro: PS2_TX_TIMEOUT_EN adds a device-clock watchdog.
// Without it, only Reset recovers a stalled frame.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2000,
    parameter int unsigned TIMEOUT_CYCLES = 300000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    // Fewer than two stages is never safe on asynchronous pad inputs.
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned INH_W  = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);

    // Each state names what the host is waiting for next on the bus.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_DATA      = 3'd3,
        S_PARITY    = 3'd4,
        S_ACK       = 3'd5,
        S_WAIT_IDLE = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    // Odd parity over the command byte: total count of ones including P is odd.
    function automatic logic f_odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    state_t            r_state;
    logic [SYNC_N-1:0] r_clk_sync;
    logic [SYNC_N-1:0] r_data_sync;
    logic              r_clk_prev;
    logic [INH_W-1:0]  r_inh_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_data;
    logic              r_parity;
    logic              r_nack;
    logic              r_clk_oe;
    logic              r_data_oe;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_clk_s;
    logic              w_data_s;
    logic              w_fall;
    logic              w_timeout;

    // Pad synchronizers; idle bus reads high, so reset to ones.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_N-2:0], PS2_CLK_IN};
            r_data_sync <= {r_data_sync[SYNC_N-2:0], PS2_DATA_IN};
            r_clk_prev  <= r_clk_sync[SYNC_N-1];
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_N-1];
    assign w_data_s = r_data_sync[SYNC_N-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_wdog;
    logic            w_wdog_active;

    assign w_wdog_active = (r_state == S_RTS) || (r_state == S_DATA) ||
                           (r_state == S_PARITY) || (r_state == S_ACK) ||
                           (r_state == S_WAIT_IDLE);
    assign w_timeout     = w_wdog_active && (r_wdog == TO_LAST);

    // Watchdog: restarts on each device falling edge; in WAIT_IDLE it only
    // restarts on entry (the ACK edge), so a stuck-low bus still times out.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wdog <= '0;
        end else if (!w_wdog_active || w_timeout) begin
            r_wdog <= '0;
        end else if (w_fall && (r_state != S_WAIT_IDLE)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Transmit FSM with registered pad enables and status outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_inh_cnt <= '0;
            r_bit_cnt <= 3'd0;
            r_data    <= 8'h00;
            r_parity  <= 1'b0;
            r_nack    <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_timeout) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_done    <= 1'b1;
                r_error   <= 1'b1;
                r_state   <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        if (iSend) begin
                            r_data    <= iData;
                            r_parity  <= f_odd_parity(iData);
                            r_nack    <= 1'b0;
                            r_busy    <= 1'b1;
                            r_clk_oe  <= 1'b1;
                            r_inh_cnt <= '0;
                            r_state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        // Host owns the clock here; device edges are ignored.
                        if (r_inh_cnt == INH_LAST) begin
                            r_data_oe <= 1'b1;
                            r_state   <= S_RTS;
                        end else if (r_inh_cnt != INH_MAX) begin
                            r_inh_cnt <= r_inh_cnt + INH_W'(1);
                        end
                    end
                    S_RTS: begin
                        // Start bit is already on the line; hand the clock over.
                        r_clk_oe <= 1'b0;
                        if (w_fall) begin
                            r_data_oe <= ~r_data[0];
                            r_bit_cnt <= 3'd0;
                            r_state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_data_oe <= ~r_parity;
                                r_state   <= S_PARITY;
                            end else begin
                                r_data_oe <= ~r_data[r_bit_cnt + 3'd1];
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        // Releasing the line here forms the stop bit.
                        if (w_fall) begin
                            r_data_oe <= 1'b0;
                            r_state   <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (w_fall) begin
                            r_nack  <= w_data_s;
                            r_state <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (w_clk_s && w_data_s) begin
                            r_done  <= 1'b1;
                            r_error <= r_nack;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign oPS2_CLK_OE  = r_clk_oe;
    assign oPS2_DATA_OE = r_data_oe;
    assign oBusy        = r_busy;
    assign oDone        = r_done;
    assign oError       = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a clocking PS/2 device model.
// Expected data-line enables and ACK outcomes are queued when a send is
// issued and consumed as the device model clocks the frame.
module tb_ps2_host_tx;

    localparam int INHIBIT = 2000;
    localparam int TIMEOUT = 300000;
    localparam int HALF    = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       send;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       pad_clk;
    logic       pad_data;
    logic       clk_oe;
    logic       data_oe;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;
    int done_total = 0;

    logic exp_oe_q[$];
    logic exp_err_q[$];

    always #5 clk = ~clk;

    assign pad_clk  = ~(clk_oe | dev_clk_low);
    assign pad_data = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES(2)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .iData(data_in),
        .iSend(send),
        .PS2_CLK_IN(pad_clk),
        .PS2_DATA_IN(pad_data),
        .oPS2_CLK_OE(clk_oe),
        .oPS2_DATA_OE(data_oe),
        .oBusy(busy),
        .oDone(done),
        .oError(error)
    );

    always @(posedge clk) begin
        if (done === 1'b1) done_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push expected DATA_OE for edges 1..10 and the expected error flag.
    task automatic push_frame(input logic [7:0] d, input logic ack_low);
        logic p;
        p = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_oe_q.push_back(~d[i]);
            if (d[i]) p = ~p;
        end
        exp_oe_q.push_back(~p);
        exp_oe_q.push_back(1'b0);
        exp_err_q.push_back(~ack_low);
    endtask

    // Issue a send and check the inhibit / request-to-send handshake timing.
    task automatic start_send(input logic [7:0] d, input logic ack_low);
        int n;
        push_frame(d, ack_low);
        data_in = d;
        send    = 1'b1;
        tick();
        send    = 1'b0;
        checks++;
        if (busy !== 1'b1 || clk_oe !== 1'b1)
            begin errors++; $display("FAIL accept: busy=%b clk_oe=%b expected 1 1", busy, clk_oe); end
        n = 0;
        while (clk_oe === 1'b1 && data_oe === 1'b0 && n < 5000) begin
            n++;
            tick();
        end
        checks++;
        if (n != INHIBIT)
            begin errors++; $display("FAIL inhibit_len: got %0d cycles expected %0d", n, INHIBIT); end
        checks++;
        if (clk_oe !== 1'b1 || data_oe !== 1'b1)
            begin errors++; $display("FAIL start_bit: clk_oe=%b data_oe=%b expected 1 1", clk_oe, data_oe); end
        tick();
        checks++;
        if (clk_oe !== 1'b0 || data_oe !== 1'b1)
            begin errors++; $display("FAIL rts: clk_oe=%b data_oe=%b expected 0 1", clk_oe, data_oe); end
    endtask

    // Device model: 11 falling edges; checks host data after edges 1..10.
    task automatic run_device(input logic ack_low, input int inject_edge, input int abort_edge);
        logic exp;
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && ack_low) dev_data_low = 1'b1;
            repeat (HALF) tick();
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            if (e <= 10) begin
                checks++;
                if (exp_oe_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: edge %0d has no expected value", e);
                end else begin
                    exp = exp_oe_q.pop_front();
                    if (data_oe !== exp)
                        begin errors++; $display("FAIL data_edge%0d: got %b expected %b", e, data_oe, exp); end
                end
            end
            if (e == abort_edge) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (clk_oe !== 1'b0 || data_oe !== 1'b0)
                    begin errors++; $display("FAIL abort_lines: clk_oe=%b data_oe=%b expected 0 0", clk_oe, data_oe); end
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0)
                    begin errors++; $display("FAIL abort_status: busy=%b done=%b error=%b expected 0 0 0", busy, done, error); end
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                exp_oe_q.delete();
                exp_err_q.delete();
                repeat (3) tick();
                rst_n = 1'b1;
                repeat (2) tick();
                return;
            end
            if (e == inject_edge) begin
                data_in = 8'hFF;
                send    = 1'b1;
                tick();
                send    = 1'b0;
            end
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    // Wait (bounded) for the completion pulse and check its status.
    task automatic wait_done();
        int   n;
        logic exp;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: no oDone within %0d cycles", n);
        end else begin
            exp = (exp_err_q.size() != 0) ? exp_err_q.pop_front() : 1'bx;
            checks++;
            if (error !== exp)
                begin errors++; $display("FAIL done_error: got %b expected %b", error, exp); end
            checks++;
            if (clk_oe !== 1'b0 || data_oe !== 1'b0 || busy !== 1'b1)
                begin errors++; $display("FAIL done_state: clk_oe=%b data_oe=%b busy=%b expected 0 0 1", clk_oe, data_oe, busy); end
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL after_done: done=%b busy=%b expected 0 0", done, busy); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; send = 1'b0; data_in = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) tick();
        checks++;
        if (clk_oe !== 1'b0 || data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0)
            begin errors++; $display("FAIL reset_outputs: %b%b%b%b%b expected 00000", clk_oe, data_oe, busy, done, error); end
        rst_n = 1'b1;
        repeat (2) tick();
        // Device clock activity while idle must not start anything.
        for (int k = 0; k < 4; k++) begin
            dev_clk_low = ~dev_clk_low;
            repeat (6) tick();
        end
        dev_clk_low = 1'b0;
        repeat (4) tick();
        checks++;
        if (clk_oe !== 1'b0 || data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL idle_edges: %b%b%b%b expected 0000", clk_oe, data_oe, busy, done); end
    endtask

    task automatic test_ack_ok();
        int d0;
        d0 = done_total;
        start_send(8'hF4, 1'b1);
        run_device(1'b1, 0, 0);
        wait_done();
        checks++;
        if (done_total - d0 != 1)
            begin errors++; $display("FAIL ack_ok_done_count: got %0d expected 1", done_total - d0); end
    endtask

    task automatic test_parity_set_leds();
        start_send(8'hED, 1'b1);
        run_device(1'b1, 0, 0);
        wait_done();
    endtask

    task automatic test_nack();
        start_send(8'h00, 1'b0);
        run_device(1'b0, 0, 0);
        wait_done();
    endtask

    task automatic test_ignore_send();
        int d0;
        d0 = done_total;
        start_send(8'h3C, 1'b1);
        run_device(1'b1, 3, 0);
        wait_done();
        repeat (6) tick();
        checks++;
        if (done_total - d0 != 1)
            begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_total - d0); end
        checks++;
        if (busy !== 1'b0 || clk_oe !== 1'b0)
            begin errors++; $display("FAIL ignore_not_queued: busy=%b clk_oe=%b expected 0 0", busy, clk_oe); end
    endtask

    task automatic test_reset_mid_frame();
        start_send(8'h5A, 1'b1);
        run_device(1'b1, 0, 5);
        start_send(8'hFF, 1'b1);
        run_device(1'b1, 0, 0);
        wait_done();
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        start_send(8'hF4, 1'b1);
        exp_oe_q.delete();
        exp_err_q.delete();
        exp_err_q.push_back(1'b1);
        n = 0;
        while (done !== 1'b1 && n < TIMEOUT + 100) begin
            n++;
            tick();
        end
        checks++;
        if (n < TIMEOUT - 2 || n > TIMEOUT + 1)
            begin errors++; $display("FAIL timeout_len: got %0d expected about %0d", n, TIMEOUT); end
        wait_done();
    endtask
`endif

    initial begin
        test_reset();
        test_ack_ok();
        test_parity_set_leds();
        test_nack();
        test_ignore_send();
        test_reset_mid_frame();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
